// File: rtl/cmd_arbiter.sv
// Command arbiter: latches button/clap event pulses as pending requests and offers
// one command at a time over valid/ready, then enforces an idle lockout.
module cmd_arbiter #(
  parameter int unsigned LOCKOUT_CYCLES = 1000000,
  parameter bit          CLAP_EN        = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btnu_i,
  input  logic       btnl_i,
  input  logic       btnd_i,
  input  logic       btnr_i,
  input  logic       btnc_i,
  input  logic       clap_set_i,
  input  logic [1:0] clap_state_i,
  output logic       cmd_valid_o,
  input  logic       cmd_ready_i,
  output logic [2:0] cmd_o,
  output logic [1:0] cmd_arg_o,
  output logic       drop_o,
  input  logic       clr_drop_i
);

  localparam int NUM_SRC  = 6;
  localparam int CLAP_IDX = 5;
  localparam int CNT_W    = 24;
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OFFER, LOCK} state_t;

  state_t               state_q;
  logic [NUM_SRC-1:0]   pend_q;
  logic [NUM_SRC-1:0]   src_set;
  logic [NUM_SRC-1:0]   grant_clr;
  logic [NUM_SRC-1:0]   pend_kept;
  logic [1:0]           arg_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 rr_q;      // 1: clap group preferred on contention
  logic                 pick_clap;
  logic [2:0]           win_idx;
  logic                 drop_evt;
  logic                 arg_cap;

  // Source index + 1 is the command code: U L D R C CLAP
  assign src_set = {clap_set_i & CLAP_EN, btnc_i, btnr_i, btnd_i, btnl_i, btnu_i};

  always_comb begin
    pick_clap = pend_q[CLAP_IDX] & (~(|pend_q[4:0]) | rr_q);
    win_idx   = 3'd3;
    if (pick_clap)      win_idx = 3'd5;
    else if (pend_q[2]) win_idx = 3'd2;
    else if (pend_q[4]) win_idx = 3'd4;
    else if (pend_q[0]) win_idx = 3'd0;
    else if (pend_q[1]) win_idx = 3'd1;
    grant_clr = '0;
    if (state_q == IDLE && (|pend_q)) grant_clr = NUM_SRC'(1) << win_idx;
  end

  // A pulse landing on a bit being granted this cycle is a fresh event, not a loss
  assign pend_kept = pend_q & ~grant_clr;
  assign drop_evt  = |(src_set & pend_kept);
  assign arg_cap   = src_set[CLAP_IDX] & ~pend_kept[CLAP_IDX];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      arg_q       <= '0;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      cmd_valid_o <= 1'b0;
      cmd_o       <= '0;
      cmd_arg_o   <= '0;
      drop_o      <= 1'b0;
    end else begin
      pend_q <= pend_kept | src_set;
      drop_o <= (drop_o & ~clr_drop_i) | drop_evt;
      if (arg_cap) arg_q <= clap_state_i;
      case (state_q)
        IDLE: begin
          if (|pend_q) begin
            cmd_valid_o <= 1'b1;
            cmd_o       <= 3'(win_idx + 3'd1);
            cmd_arg_o   <= pick_clap ? arg_q : 2'd0;
            rr_q        <= ~pick_clap;
            state_q     <= OFFER;
          end
        end
        OFFER: begin
          if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            cmd_o       <= '0;
            cmd_arg_o   <= '0;
            cnt_q       <= LOCK_LOAD;
            state_q     <= LOCK;
          end
        end
        LOCK: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Scoreboarded bench for cmd_arbiter: a 4-cycle-lockout instance with clap enabled
// and a second instance with the clap source disabled.
module tb_cmd_arbiter;
  localparam int LOCK = 4;

  typedef struct packed {
    logic [2:0] cmd;
    logic [1:0] arg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btnu, btnl, btnd, btnr, btnc, clap_set, ready, clr_drop;
  logic [1:0] clap_state;
  logic       a_valid, a_drop;
  logic [2:0] a_cmd;
  logic [1:0] a_arg;
  logic       b_clap_set, b_valid, b_drop;
  logic [1:0] b_clap_state;
  logic [2:0] b_cmd;
  logic [1:0] b_arg;

  int   tests = 0;
  int   fails = 0;
  int   b_vcnt = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cmd_arbiter #(.LOCKOUT_CYCLES(LOCK), .CLAP_EN(1'b1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .btnu_i(btnu), .btnl_i(btnl), .btnd_i(btnd), .btnr_i(btnr), .btnc_i(btnc),
    .clap_set_i(clap_set), .clap_state_i(clap_state),
    .cmd_valid_o(a_valid), .cmd_ready_i(ready), .cmd_o(a_cmd), .cmd_arg_o(a_arg),
    .drop_o(a_drop), .clr_drop_i(clr_drop)
  );

  cmd_arbiter #(.LOCKOUT_CYCLES(LOCK), .CLAP_EN(1'b0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .btnu_i(1'b0), .btnl_i(1'b0), .btnd_i(1'b0), .btnr_i(1'b0), .btnc_i(1'b0),
    .clap_set_i(b_clap_set), .clap_state_i(b_clap_state),
    .cmd_valid_o(b_valid), .cmd_ready_i(1'b1), .cmd_o(b_cmd), .cmd_arg_o(b_arg),
    .drop_o(b_drop), .clr_drop_i(1'b0)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] c, input logic [1:0] a);
    exp_t e;
    e.cmd = c;
    e.arg = a;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!a_valid && n < 50) begin cyc(); n++; end
    chk("wait_valid", a_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || a_valid) && n < 200) begin cyc(); n++; end
    chk("drain_q", exp_q.size(), 0);
    chk("drain_vld", a_valid, 0);
    repeat (LOCK + 2) cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Scoreboard: every accepted transfer must match the oldest expected command
  always @(negedge clk) begin
    if (rst_n && a_valid && ready) begin
      if (exp_q.size() == 0) chk("unexpected_cmd", exp_q.size(), 1);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_cmd", a_cmd, e.cmd);
        chk("sb_arg", a_arg, e.arg);
      end
    end
  end

  always @(negedge clk) if (b_valid) b_vcnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    {btnu, btnl, btnd, btnr, btnc, clap_set, clr_drop} = '0;
    clap_state = '0; b_clap_set = 1'b0; b_clap_state = '0;
    ready = 1'b1;
    cyc(); cyc();
    chk("rst_vld", a_valid, 0);
    chk("rst_cmd", a_cmd, 0);
    chk("rst_arg", a_arg, 0);
    chk("rst_drop", a_drop, 0);
    rst_n = 1'b1;
    cyc();

    // Latency and lockout length: UP at cycle 0, LEFT queued during lock
    btnu = 1'b1; push(3'd1, 2'd0);
    chk("lat_c0_vld", a_valid, 0);
    cyc(); btnu = 1'b0;
    chk("lat_c1_vld", a_valid, 0);
    cyc();
    chk("lat_c2_vld", a_valid, 1);
    chk("lat_c2_cmd", a_cmd, 1);
    chk("lat_c2_arg", a_arg, 0);
    cyc();
    chk("lat_c3_vld", a_valid, 0);
    chk("lat_c3_cmd", a_cmd, 0);
    cyc(); chk("lat_c4_vld", a_valid, 0);
    cyc(); chk("lat_c5_vld", a_valid, 0);
    btnl = 1'b1; push(3'd2, 2'd0);
    cyc(); btnl = 1'b0; chk("lat_c6_vld", a_valid, 0);
    cyc(); chk("lat_c7_vld", a_valid, 0);
    cyc();
    chk("lat_c8_vld", a_valid, 1);
    chk("lat_c8_cmd", a_cmd, 2);
    drain();

    // Round-robin from reset: DOWN, CLAP(2), LEFT
    do_reset();
    btnd = 1'b1; btnl = 1'b1; clap_set = 1'b1; clap_state = 2'd2;
    push(3'd3, 2'd0); push(3'd6, 2'd2); push(3'd2, 2'd0);
    cyc();
    {btnd, btnl, clap_set} = '0; clap_state = 2'd0;
    drain();

    // Backpressure: CENTER held 10 cycles, RIGHT arrives meanwhile
    ready = 1'b0;
    btnc = 1'b1; push(3'd5, 2'd0);
    cyc(); btnc = 1'b0;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      chk("hold_vld", a_valid, 1);
      chk("hold_cmd", a_cmd, 5);
      if (i == 3) begin btnr = 1'b1; push(3'd4, 2'd0); end
      else btnr = 1'b0;
      cyc();
    end
    btnr = 1'b0;
    ready = 1'b1;
    drain();

    // Duplicate CENTER during lock -> one command plus drop
    btnu = 1'b1; push(3'd1, 2'd0); push(3'd5, 2'd0);
    cyc(); btnu = 1'b0;
    wait_valid();
    cyc();
    btnc = 1'b1; cyc(); btnc = 1'b0;
    cyc(); cyc();
    btnc = 1'b1; cyc(); btnc = 1'b0;
    chk("dup_drop", a_drop, 1);
    drain();
    clr_drop = 1'b1;
    chk("clr_pre", a_drop, 1);
    cyc(); clr_drop = 1'b0;
    chk("clr_post", a_drop, 0);

    // Repeated clap keeps first argument; drop set wins over simultaneous clear
    btnu = 1'b1; push(3'd1, 2'd0); push(3'd6, 2'd1);
    cyc(); btnu = 1'b0;
    wait_valid();
    cyc();
    clap_set = 1'b1; clap_state = 2'd1;
    cyc(); clap_set = 1'b0; clap_state = 2'd0;
    cyc();
    clap_set = 1'b1; clap_state = 2'd3; clr_drop = 1'b1;
    cyc(); clap_set = 1'b0; clap_state = 2'd0; clr_drop = 1'b0;
    chk("clap_drop_win", a_drop, 1);
    drain();

    // Reset mid-lock with LEFT and RIGHT pending
    clr_drop = 1'b1; cyc(); clr_drop = 1'b0;
    btnu = 1'b1; push(3'd1, 2'd0);
    cyc(); btnu = 1'b0;
    wait_valid();
    cyc();
    btnl = 1'b1; btnr = 1'b1;
    cyc(); btnr = 1'b0;
    cyc(); btnl = 1'b0;
    chk("pre_rst_drop", a_drop, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_vld", a_valid, 0);
    chk("async_cmd", a_cmd, 0);
    chk("async_arg", a_arg, 0);
    chk("async_drop", a_drop, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    begin
      int vc = 0;
      for (int i = 0; i < 12; i++) begin cyc(); if (a_valid) vc++; end
      chk("post_rst_vld_cycles", vc, 0);
    end

    // Clap-disabled instance: repeated clap pulses are ignored
    for (int i = 0; i < 8; i++) begin
      b_clap_set = 1'b1; b_clap_state = 2'(i);
      cyc();
      if (i % 3 == 0) begin b_clap_set = 1'b0; cyc(); end
    end
    b_clap_set = 1'b0;
    repeat (10) cyc();
    chk("noclap_vld_cycles", b_vcnt, 0);
    chk("noclap_drop", b_drop, 0);
    chk("noclap_cmd", b_cmd, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
